decoder_port: RTL and testbench

I2S master port between the audio DSP core and an external audio codec. It generates MCLK, BCLK and LRCLK from the single `audio_clk`. It serialises a 24-bit stereo playback sample pair onto `DAC_SDATA` and deserialises `ADC_SDATA` into a 24-bit stereo record pair. A `NewFrame` strobe marks each completed record frame for the downstream DSP.

---
 rtl/decoder_pkg.sv | 38 +++
 rtl/decoder_port_i2s_clkgen.sv | 36 +++
 rtl/decoder_port.sv | 117 +++++++++++
 tb/tb_decoder_port.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants, types and bit-slot helpers for the I2S master port.
package decoder_pkg;

    localparam int DATA_W         = 24;
    localparam int SLOT_W         = 32;
    localparam int FRAME_CLKS     = 256;
    localparam int BCLK_DIV       = 4;
    localparam int FIRST_DATA_BIT = 1;
    localparam int LAST_DATA_BIT  = 24;

    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int BIT_LSB    = $clog2(BCLK_DIV);
    localparam int SLOT_IDX_W = $clog2(SLOT_W);

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    function automatic logic is_data_bit(input logic [SLOT_IDX_W-1:0] s);
        return (int'(s) >= FIRST_DATA_BIT) && (int'(s) <= LAST_DATA_BIT);
    endfunction

    // Slot index 1 carries the sample MSB; the delay bit and padding carry 0.
    function automatic logic tx_bit(input sample_t data, input logic [SLOT_IDX_W-1:0] s);
        sample_t shifted;
        logic    result;
        result  = 1'b0;
        shifted = data >> (LAST_DATA_BIT - int'(s));
        if (is_data_bit(s)) begin
            result = shifted[0];
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_port_i2s_clkgen.sv
// Free-running frame counter with codec clock decode and bit-phase strobes.
module i2s_clkgen
    import decoder_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             mclk_o,
    output logic             bclk_o,
    output logic             lrclk_o,
    output logic             tx_load_o,
    output logic             rx_sample_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tx_load lands on the BCLK falling edge, rx_sample on the rising edge.
    assign cnt_o       = cnt_q;
    assign mclk_o      = cnt_q[0];
    assign bclk_o      = cnt_q[1];
    assign lrclk_o     = cnt_q[CNT_W-1];
    assign tx_load_o   = (cnt_q[1:0] == 2'b11);
    assign rx_sample_o = (cnt_q[1:0] == 2'b01);

endmodule

// File: rtl/decoder_port.sv
// I2S master: playback serialiser, record deserialiser and frame strobe.
module decoder_port
    import decoder_pkg::*;
(
    input  logic              audio_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] LeftPlayData,
    input  logic [DATA_W-1:0] RightPlayData,
    input  logic              ADC_SDATA,
    output logic              MCLK,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              DAC_SDATA,
    output logic [DATA_W-1:0] LeftRecData,
    output logic [DATA_W-1:0] RightRecData,
    output logic              NewFrame
);

    logic [CNT_W-1:0] cnt;
    logic             txLoad;
    logic             rxSample;

    i2s_clkgen u_clkgen (
        .clk_i       (audio_clk),
        .rst_i       (reset),
        .cnt_o       (cnt),
        .mclk_o      (MCLK),
        .bclk_o      (BCLK),
        .lrclk_o     (LRCLK),
        .tx_load_o   (txLoad),
        .rx_sample_o (rxSample)
    );

    logic                          frameEnd;
    slot_e                         curSlot;
    logic [SLOT_IDX_W-1:0]         curBit;
    logic [CNT_W-BIT_LSB-1:0]      nextWord;
    slot_e                         nextSlot;
    logic [SLOT_IDX_W-1:0]         nextBit;

    // The load happens on the last cycle of a bit, so it prepares the following bit.
    assign frameEnd = &cnt;
    assign curSlot  = slot_e'(cnt[CNT_W-1]);
    assign curBit   = cnt[BIT_LSB +: SLOT_IDX_W];
    assign nextWord = cnt[CNT_W-1:BIT_LSB] + (CNT_W-BIT_LSB)'(1);
    assign nextSlot = slot_e'(nextWord[CNT_W-BIT_LSB-1]);
    assign nextBit  = nextWord[SLOT_IDX_W-1:0];

    sample_t shadowLeft_q,  shadowLeft_d;
    sample_t shadowRight_q, shadowRight_d;
    sample_t shiftLeft_q,   shiftLeft_d;
    sample_t shiftRight_q,  shiftRight_d;
    sample_t recLeft_q,     recLeft_d;
    sample_t recRight_q,    recRight_d;
    logic    dac_q,         dac_d;
    logic    newFrame_q,    newFrame_d;

    always_comb begin
        shadowLeft_d  = shadowLeft_q;
        shadowRight_d = shadowRight_q;
        shiftLeft_d   = shiftLeft_q;
        shiftRight_d  = shiftRight_q;
        recLeft_d     = recLeft_q;
        recRight_d    = recRight_q;
        dac_d         = dac_q;
        newFrame_d    = 1'b0;

        if (frameEnd) begin
            shadowLeft_d  = LeftPlayData;
            shadowRight_d = RightPlayData;
            recLeft_d     = shiftLeft_q;
            recRight_d    = shiftRight_q;
            newFrame_d    = 1'b1;
        end

        if (txLoad) begin
            dac_d = tx_bit((nextSlot == SLOT_RIGHT) ? shadowRight_q : shadowLeft_q, nextBit);
        end

        // Exactly DATA_W bits land per slot, so the shifters never need clearing.
        if (rxSample && is_data_bit(curBit)) begin
            if (curSlot == SLOT_RIGHT) begin
                shiftRight_d = {shiftRight_q[DATA_W-2:0], ADC_SDATA};
            end else begin
                shiftLeft_d = {shiftLeft_q[DATA_W-2:0], ADC_SDATA};
            end
        end
    end

    always_ff @(posedge audio_clk) begin
        if (reset) begin
            shadowLeft_q  <= '0;
            shadowRight_q <= '0;
            shiftLeft_q   <= '0;
            shiftRight_q  <= '0;
            recLeft_q     <= '0;
            recRight_q    <= '0;
            dac_q         <= 1'b0;
            newFrame_q    <= 1'b0;
        end else begin
            shadowLeft_q  <= shadowLeft_d;
            shadowRight_q <= shadowRight_d;
            shiftLeft_q   <= shiftLeft_d;
            shiftRight_q  <= shiftRight_d;
            recLeft_q     <= recLeft_d;
            recRight_q    <= recRight_d;
            dac_q         <= dac_d;
            newFrame_q    <= newFrame_d;
        end
    end

    assign DAC_SDATA    = dac_q;
    assign LeftRecData  = recLeft_q;
    assign RightRecData = recRight_q;
    assign NewFrame     = newFrame_q;

endmodule

// File: tb/tb_decoder_port.sv
// Directed bench for decoder_port; cycle k after reset release has cnt = k mod 256.
module tb_decoder_port;

    logic        audio_clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] leftPlay = '0;
    logic [23:0] rightPlay = '0;
    logic        adcDrive = 1'b0;
    logic        loopback = 1'b0;
    logic        adcIn;
    logic        mclk, bclk, lrclk, dac, newFrame;
    logic [23:0] leftRec, rightRec;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    assign adcIn = loopback ? dac : adcDrive;

    always #5 audio_clk = ~audio_clk;

    decoder_port dut (
        .audio_clk     (audio_clk),
        .reset         (reset),
        .LeftPlayData  (leftPlay),
        .RightPlayData (rightPlay),
        .ADC_SDATA     (adcIn),
        .MCLK          (mclk),
        .BCLK          (bclk),
        .LRCLK         (lrclk),
        .DAC_SDATA     (dac),
        .LeftRecData   (leftRec),
        .RightRecData  (rightRec),
        .NewFrame      (newFrame)
    );

    // Outputs are observed on the falling edge, half a cycle away from the active edge.
    task automatic tick;
        @(negedge audio_clk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset;
        @(negedge audio_clk);
        reset = 1'b1;
        repeat (2) @(negedge audio_clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        leftPlay  = 24'hFFFFFF;
        rightPlay = 24'hFFFFFF;
        adcDrive  = 1'b1;
        loopback  = 1'b0;
        @(negedge audio_clk);
        reset = 1'b1;
        @(negedge audio_clk);
        vectors++;
        if ({mclk, bclk, lrclk, dac, newFrame} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_bits: got %b, expected 00000", {mclk, bclk, lrclk, dac, newFrame});
        end
        vectors++;
        if (leftRec !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_leftrec: got %h, expected 000000", leftRec);
        end
        vectors++;
        if (rightRec !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rightrec: got %h, expected 000000", rightRec);
        end
        @(negedge audio_clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_clocks;
        logic [7:0] c;
        logic [2:0] expClk;
        leftPlay  = '0;
        rightPlay = '0;
        adcDrive  = 1'b0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            c = 8'(k);
            expClk = {c[0], c[1], c[7]};
            vectors++;
            if ({mclk, bclk, lrclk} !== expClk) begin
                miscompares++;
                $display("[TB] FAIL clocks at cycle %0d: got %b, expected %b", cyc, {mclk, bclk, lrclk}, expClk);
            end
            tick();
        end
    endtask

    task automatic test_loopback;
        leftPlay  = 24'hA5A5A5;
        rightPlay = 24'h5A5A5A;
        loopback  = 1'b1;
        do_reset();
        run_to(256);
        vectors++;
        if ({newFrame, leftRec, rightRec} !== {1'b1, 48'h0}) begin
            miscompares++;
            $display("[TB] FAIL loopback_first_frame: got %b %h %h, expected 1 000000 000000", newFrame, leftRec, rightRec);
        end
        for (int f = 2; f <= 4; f++) begin
            run_to(256 * f);
            vectors++;
            if ({newFrame, leftRec, rightRec} !== {1'b1, 24'hA5A5A5, 24'h5A5A5A}) begin
                miscompares++;
                $display("[TB] FAIL loopback_frame%0d: got %b %h %h, expected 1 a5a5a5 5a5a5a", f, newFrame, leftRec, rightRec);
            end
        end
        run_to(1024 + 100);
        vectors++;
        if ({newFrame, leftRec, rightRec} !== {1'b0, 24'hA5A5A5, 24'h5A5A5A}) begin
            miscompares++;
            $display("[TB] FAIL loopback_hold: got %b %h %h, expected 0 a5a5a5 5a5a5a", newFrame, leftRec, rightRec);
        end
        loopback = 1'b0;
    endtask

    task automatic test_serial_format;
        int  c;
        logic expDac;
        leftPlay  = 24'h800001;
        rightPlay = 24'h000000;
        adcDrive  = 1'b0;
        do_reset();
        for (int k = 0; k < 512; k++) begin
            c = k % 256;
            expDac = (k >= 256) && ((c >= 4 && c <= 7) || (c >= 96 && c <= 99));
            vectors++;
            if (dac !== expDac) begin
                miscompares++;
                $display("[TB] FAIL serial_format at cycle %0d: got %b, expected %b", cyc, dac, expDac);
            end
            tick();
        end
    endtask

    task automatic test_latch_point;
        leftPlay  = 24'hFFF000;
        rightPlay = 24'h00F00F;
        loopback  = 1'b1;
        do_reset();
        run_to(256 + 100);
        leftPlay = 24'h0000FF;
        run_to(512);
        vectors++;
        if ({leftRec, rightRec} !== {24'hFFF000, 24'h00F00F}) begin
            miscompares++;
            $display("[TB] FAIL latch_old_value: got %h %h, expected fff000 00f00f", leftRec, rightRec);
        end
        run_to(512 + 40);
        leftPlay = 24'h123456;
        run_to(768);
        vectors++;
        if ({leftRec, rightRec} !== {24'h0000FF, 24'h00F00F}) begin
            miscompares++;
            $display("[TB] FAIL latch_new_value: got %h %h, expected 0000ff 00f00f", leftRec, rightRec);
        end
        run_to(1024);
        vectors++;
        if (leftRec !== 24'h123456) begin
            miscompares++;
            $display("[TB] FAIL latch_midslot_change: got %h, expected 123456", leftRec);
        end
        loopback = 1'b0;
    endtask

    task automatic test_record_only;
        logic expNf;
        leftPlay  = '0;
        rightPlay = '0;
        adcDrive  = 1'b1;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            expNf = (k == 256) || (k == 512);
            vectors++;
            if (newFrame !== expNf) begin
                miscompares++;
                $display("[TB] FAIL record_strobe at cycle %0d: got %b, expected %b", cyc, newFrame, expNf);
            end
            if (k == 256) begin
                vectors++;
                if ({leftRec, rightRec} !== {24'hFFFFFF, 24'hFFFFFF}) begin
                    miscompares++;
                    $display("[TB] FAIL record_ones: got %h %h, expected ffffff ffffff", leftRec, rightRec);
                end
            end
            tick();
        end
        adcDrive = 1'b0;
    endtask

    task automatic test_mid_frame_reset;
        logic [7:0] c;
        leftPlay  = 24'hA5A5A5;
        rightPlay = 24'h5A5A5A;
        loopback  = 1'b1;
        do_reset();
        run_to(512);
        vectors++;
        if ({leftRec, rightRec} !== {24'hA5A5A5, 24'h5A5A5A}) begin
            miscompares++;
            $display("[TB] FAIL midreset_prefill: got %h %h, expected a5a5a5 5a5a5a", leftRec, rightRec);
        end
        run_to(512 + 180);
        reset = 1'b1;
        @(negedge audio_clk);
        vectors++;
        if ({newFrame, leftRec, rightRec} !== 49'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_clear: got %b %h %h, expected 0 000000 000000", newFrame, leftRec, rightRec);
        end
        @(negedge audio_clk);
        reset = 1'b0;
        cyc = 0;
        for (int k = 0; k < 256; k++) begin
            c = 8'(k);
            vectors++;
            if ({newFrame, leftRec, rightRec} !== 49'h0) begin
                miscompares++;
                $display("[TB] FAIL midreset_quiet at cycle %0d: got %b %h %h, expected 0 000000 000000", cyc, newFrame, leftRec, rightRec);
            end
            if (k < 8) begin
                vectors++;
                if ({mclk, bclk, lrclk} !== {c[0], c[1], c[7]}) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_restart at cycle %0d: got %b, expected %b", cyc, {mclk, bclk, lrclk}, {c[0], c[1], c[7]});
                end
            end
            tick();
        end
        vectors++;
        if ({newFrame, leftRec, rightRec} !== {1'b1, 48'h0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_first_strobe: got %b %h %h, expected 1 000000 000000", newFrame, leftRec, rightRec);
        end
        run_to(512);
        vectors++;
        if ({newFrame, leftRec, rightRec} !== {1'b1, 24'hA5A5A5, 24'h5A5A5A}) begin
            miscompares++;
            $display("[TB] FAIL midreset_recover: got %b %h %h, expected 1 a5a5a5 5a5a5a", newFrame, leftRec, rightRec);
        end
        loopback = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_loopback();
        test_serial_format();
        test_latch_point();
        test_record_only();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
